// File: rtl/quant_issue.sv
// Quantization issue stage: pairs each DCT coefficient with its float-converted
// quantization step for the divider, and delays an index sideband to meet the quotient.
module quant_issue #(
  parameter int NTAB    = 2,
  parameter int DIV_LAT = 28,
  localparam int TSW    = (NTAB > 1) ? $clog2(NTAB) : 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            cfg_we,
  input  logic [TSW-1:0]  cfg_tab,
  input  logic [5:0]      cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic            flush,
  input  logic [31:0]     coef_in,
  input  logic            coef_valid,
  input  logic [TSW-1:0]  coef_tab,
  output logic [31:0]     div_din1,
  output logic [31:0]     div_din2,
  output logic            div_valid,
  output logic [5:0]      q_idx,
  output logic            q_last,
  output logic            q_valid
);

  logic [7:0]     tab_q [NTAB][64];
  logic [5:0]     idx_q, idx_d, rd_idx;
  logic [TSW-1:0] cur_tab_q, cur_tab_d, sel;
  logic [7:0]     step, step_nz, step_norm;
  logic [2:0]     msb;
  logic [31:0]    step_f;
  logic           div_valid_q;
  logic [31:0]    din1_q, din2_q;
  logic [5:0]     iss_idx_q;
  logic [DIV_LAT-1:0] sb_vld_q;
  logic [6:0]     sb_dat_q [DIV_LAT];

  // NOTE: the step table is plain storage with no reset; contents are undefined until
  // written, which keeps it mappable to register-file or LUT-RAM structures.
  always_ff @(posedge clk) begin
    if (cfg_we) tab_q[cfg_tab][cfg_addr] <= cfg_data;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_idx    = flush ? 6'd0 : idx_q;
    sel       = (rd_idx == 6'd0) ? coef_tab : cur_tab_q;
    step      = tab_q[sel][rd_idx];
    idx_d     = idx_q;
    cur_tab_d = cur_tab_q;
    if (coef_valid) begin
      idx_d = rd_idx + 6'd1;
      if (rd_idx == 6'd0) cur_tab_d = coef_tab;
    end else if (flush) begin
      idx_d = 6'd0;
    end
  end

  // Exact unsigned-to-float: a zero step is illegal and treated as 1.
  always_comb begin
    step_nz = (step == 8'd0) ? 8'd1 : step;
    msb     = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (step_nz[i]) msb = 3'(i);
    end
    step_norm = step_nz << (3'd7 - msb);
    step_f    = {1'b0, 8'd127 + {5'd0, msb}, step_norm[6:0], 16'd0};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q       <= 6'd0;
      cur_tab_q   <= '0;
      div_valid_q <= 1'b0;
      din1_q      <= 32'd0;
      din2_q      <= 32'd0;
    end else begin
      idx_q       <= idx_d;
      cur_tab_q   <= cur_tab_d;
      div_valid_q <= coef_valid;
      if (coef_valid) begin
        din1_q <= coef_in;
        din2_q <= step_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (coef_valid) iss_idx_q <= rd_idx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sb_vld_q <= '0;
    end else begin
      sb_vld_q[0] <= div_valid_q;
      for (int i = 1; i < DIV_LAT; i++) sb_vld_q[i] <= sb_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sb_dat_q[0] <= {iss_idx_q, iss_idx_q == 6'd63};
    for (int i = 1; i < DIV_LAT; i++) sb_dat_q[i] <= sb_dat_q[i-1];
  end

  assign div_valid = div_valid_q;
  assign div_din1  = din1_q;
  assign div_din2  = din2_q;
  assign q_valid   = sb_vld_q[DIV_LAT-1];
  // Unreset sideband data is masked so idle outputs read as zero.
  assign q_idx     = q_valid ? sb_dat_q[DIV_LAT-1][6:1] : 6'd0;
  assign q_last    = q_valid & sb_dat_q[DIV_LAT-1][0];

endmodule
